// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared widths, image geometry, FSM states and address pack helper for lbp_host_mem
package lbp_pkg;

  localparam int LBP_ADDR_W = 14;
  localparam int LBP_DATA_W = 8;
  localparam int IMG_W      = 128;
  localparam int IMG_H      = 128;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Raster address is {row, col}, each 7 bits for a 128x128 image.
  function automatic logic [LBP_ADDR_W-1:0] lbp_pack_addr(input logic [6:0] row,
                                                         input logic [6:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/lbp_sp_ram.sv
// rtl/lbp_sp_ram.sv - one synchronous write port, one asynchronous read port memory
module lbp_sp_ram
  import lbp_pkg::*;
#(
  parameter int ADDR_W = LBP_ADDR_W,
  parameter int DATA_W = LBP_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Contents deliberately survive reset; no reset branch here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_host_mem.sv
// rtl/lbp_host_mem.sv - LBP host memory responder: image load, serve reads/writes, result dump
// Optional protocol checker (err, wr_cnt ports) enabled by defining LBP_HOST_PROTOCOL_CHECK_EN.
module lbp_host_mem
  import lbp_pkg::*;
#(
  parameter int ADDR_W = LBP_ADDR_W,
  parameter int DATA_W = LBP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [DATA_W-1:0] img_data,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              done
`ifdef LBP_HOST_PROTOCOL_CHECK_EN
  ,
  output logic              err,
  output logic [ADDR_W:0]   wr_cnt
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_last;
  logic              img_we;
  logic              res_we;
  logic [DATA_W-1:0] img_rdata;
  logic [DATA_W-1:0] res_rdata;

  assign cnt_last = &cnt;
  assign img_we   = (state == ST_LOAD) && img_valid;
  assign res_we   = (state == ST_SERVE) && lbp_valid;

  lbp_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_img_ram (
    .clk   (clk),
    .we    (img_we),
    .waddr (cnt),
    .wdata (img_data),
    .raddr (gray_addr),
    .rdata (img_rdata)
  );

  lbp_sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_res_ram (
    .clk   (clk),
    .we    (res_we),
    .waddr (lbp_addr),
    .wdata (lbp_data),
    .raddr (cnt),
    .rdata (res_rdata)
  );

  assign gray_data = (gray_ready && gray_req) ? img_rdata : '0;
  assign res_addr  = res_valid ? cnt : '0;
  assign res_data  = res_valid ? res_rdata : '0;

  // One counter serves both the load index and the dump index; it wraps to 0 between them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      img_ready  <= 1'b1;
      gray_ready <= 1'b0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (img_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt_last) begin
              state      <= ST_SERVE;
              img_ready  <= 1'b0;
              gray_ready <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (finish) begin
            state      <= ST_DUMP;
            gray_ready <= 1'b0;
            res_valid  <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (res_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt_last) begin
              state     <= ST_DONE;
              res_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_LOAD;
      endcase
    end
  end

`ifdef LBP_HOST_PROTOCOL_CHECK_EN
  logic viol;

  assign viol = ((gray_req || lbp_valid || finish) && (state != ST_SERVE)) ||
                (img_valid && (state != ST_LOAD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err    <= 1'b0;
      wr_cnt <= '0;
    end else begin
      if (viol) begin
        err <= 1'b1;
      end
      if (res_we && !(&wr_cnt)) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
// tb/tb_lbp_host_mem.sv - self-checking bench for lbp_host_mem against a phase-level model
// Checker ports are exercised when LBP_HOST_PROTOCOL_CHECK_EN is defined.
module tb_lbp_host_mem;
  import lbp_pkg::*;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          img_valid = 1'b0;
  logic          img_ready;
  logic [DW-1:0] img_data = '0;
  logic          gray_ready;
  logic          gray_req = 1'b0;
  logic [AW-1:0] gray_addr = '0;
  logic [DW-1:0] gray_data;
  logic          lbp_valid = 1'b0;
  logic [AW-1:0] lbp_addr = '0;
  logic [DW-1:0] lbp_data = '0;
  logic          finish = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          done;
`ifdef LBP_HOST_PROTOCOL_CHECK_EN
  logic          err;
  logic [AW:0]   wr_cnt;
`endif

  lbp_host_mem dut (
    .clk        (clk),
    .reset      (reset),
    .img_valid  (img_valid),
    .img_ready  (img_ready),
    .img_data   (img_data),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_addr   (res_addr),
    .res_data   (res_data),
    .done       (done)
`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    ,
    .err        (err),
    .wr_cnt     (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Phase-level model: 0 load, 1 serve, 2 dump, 3 done.
  int            m_ph   = 0;
  int            m_lcnt = 0;
  int            m_didx = 0;
  int            m_wr   = 0;
  bit            m_err  = 1'b0;
  logic [DW-1:0] img_m [N];
  logic [DW-1:0] res_m [N];
  bit            res_w [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph   <= 0;
      m_lcnt <= 0;
      m_didx <= 0;
      m_wr   <= 0;
      m_err  <= 1'b0;
    end else begin
      if (((gray_req || lbp_valid || finish) && m_ph != 1) || (img_valid && m_ph != 0))
        m_err <= 1'b1;
      if (m_ph == 0) begin
        if (img_valid) begin
          img_m[m_lcnt] <= img_data;
          if (m_lcnt == N - 1) begin
            m_lcnt <= 0;
            m_ph   <= 1;
          end else begin
            m_lcnt <= m_lcnt + 1;
          end
        end
      end else if (m_ph == 1) begin
        if (lbp_valid) begin
          res_m[lbp_addr] <= lbp_data;
          res_w[lbp_addr] <= 1'b1;
          if (m_wr < 2 * N - 1) m_wr <= m_wr + 1;
        end
        if (finish) m_ph <= 2;
      end else if (m_ph == 2) begin
        if (res_ready) begin
          if (m_didx == N - 1) m_ph <= 3;
          else m_didx <= m_didx + 1;
        end
      end
    end
  end

  int            dut_hs = 0;
  logic [DW-1:0] got_081 = '0;
  logic [DW-1:0] got_3f7e = '0;

  always @(negedge clk) begin
    check("img_ready", img_ready, m_ph == 0);
    check("gray_ready", gray_ready, m_ph == 1);
    check("res_valid", res_valid, m_ph == 2);
    check("done", done, m_ph == 3);
    check("gray_data", gray_data, (m_ph == 1 && gray_req) ? img_m[gray_addr] : 8'h00);
    if (m_ph == 2) begin
      check("res_addr", res_addr, m_didx);
      if (res_w[m_didx]) check("res_data", res_data, res_m[m_didx]);
    end
`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    check("err", err, m_err);
    check("wr_cnt", wr_cnt, m_wr);
`endif
    if (res_valid && res_ready) begin
      dut_hs++;
      if (res_addr == 14'h0081) got_081 = res_data;
      if (res_addr == 14'h3F7E) got_3f7e = res_data;
    end
  end

  initial begin
    int cyc;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_img_ready", img_ready, 1);
    check("rst_gray_ready", gray_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_gray_data", gray_data, 0);
    check("rst_res_addr", res_addr, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Ramp load with img_valid toggling every cycle.
    for (int i = 0; i < N; i++) begin
      img_valid = 1'b1;
      img_data  = i[7:0];
      if (i == N - 1) begin
        @(negedge clk);
        check("gray_ready_before_last", gray_ready, 0);
      end
      step();
      img_valid = 1'b0;
      img_data  = 8'($urandom_range(0, 255));
      if (i == N - 1) begin
        @(negedge clk);
        check("gray_ready_after_last", gray_ready, 1);
        check("img_ready_after_last", img_ready, 0);
      end
      step();
    end

    gray_req  = 1'b1;
    gray_addr = lbp_pack_addr(7'd1, 7'd1);
    @(negedge clk);
    check("gray_0081", gray_data, 8'h81);
    step();
    gray_addr = 14'h3FFF;
    @(negedge clk);
    check("gray_3fff", gray_data, 8'hFF);
    step();
    gray_req = 1'b0;
    @(negedge clk);
    check("gray_noreq", gray_data, 8'h00);
    step();

    lbp_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      lbp_addr = 14'((k * 83 + 5) % N);
      lbp_data = 8'((k * 7) ^ 8'h3C);
      step();
    end
    lbp_addr = 14'h0081; lbp_data = 8'hA5; step();
    lbp_data = 8'h5A; step();
    finish   = 1'b1;
    lbp_addr = 14'h3F7E; lbp_data = 8'h3C; step();
    finish    = 1'b0;
    lbp_valid = 1'b0;
    @(negedge clk);
    check("dump_entry_valid", res_valid, 1);
    check("dump_entry_addr", res_addr, 0);

    cyc = 0;
    while (!done && cyc < 40000) begin
      res_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    res_ready = 1'b0;
    @(negedge clk);
    check("dump_done", done, 1);
    check("dump_res_valid_low", res_valid, 0);
    check("dump_word_count", dut_hs, N);
    check("dump_word_0081", got_081, 8'h5A);
    check("dump_word_3f7e", got_3f7e, 8'h3C);
`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    check("wr_cnt_total", wr_cnt, 203);
`endif

    img_valid = 1'b1; gray_req = 1'b1; lbp_valid = 1'b1; finish = 1'b1; res_ready = 1'b1;
    repeat (3) step();
    img_valid = 1'b0; gray_req = 1'b0; lbp_valid = 1'b0; finish = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check("done_sticky", done, 1);
    check("done_res_valid", res_valid, 0);

    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst2_img_ready", img_ready, 1);
    check("rst2_done", done, 0);
    step();
    reset = 1'b0;

`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    gray_req = 1'b1;
    step();
    gray_req = 1'b0;
    @(negedge clk);
    check("err_gray_in_load", err, 1);
`endif

    for (int i = 0; i < N; i++) begin
      img_valid = 1'b1;
      img_data  = i[7:0] ^ 8'h5A;
      step();
    end
    img_valid = 1'b0;
    gray_req  = 1'b1;
    gray_addr = 14'h0081;
    @(negedge clk);
    check("reload_gray_0081", gray_data, 8'hDB);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_serve_gray_ready", gray_ready, 0);
    check("rst_serve_img_ready", img_ready, 1);
    check("rst_serve_gray_data", gray_data, 0);
`ifdef LBP_HOST_PROTOCOL_CHECK_EN
    check("rst_serve_err", err, 0);
`endif
    step();
    reset    = 1'b0;
    gray_req = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lbp_host_mem.md
Name: lbp_host_mem

Overview:
- Host-side responder for the LBP engine's two memory interfaces.
- Accepts a raster-order grayscale image over a valid/ready stream into a 16K×8 image store, then asserts gray_ready.
- Serves gray_addr reads with zero latency and captures lbp_addr/lbp_data writes into a 16K×8 result store.
- After the engine pulses finish, streams the whole result store out over a valid/ready stream, then raises done.

Parameters:
- ADDR_W, 14, address width; image is 2^ADDR_W pixels (128×128 at default).
- DATA_W, 8, pixel and LBP code width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- img_valid  in  1  load-stream data valid.
- img_ready  out  1  load-stream ready.
- img_data  in  DATA_W  load-stream pixel, raster order from address 0.
- gray_ready  out  1  image loaded, reads may start.
- gray_req  in  1  engine read request.
- gray_addr  in  ADDR_W  read address {row,col}.
- gray_data  out  DATA_W  read data, combinational.
- lbp_valid  in  1  result write strobe.
- lbp_addr  in  ADDR_W  result write address.
- lbp_data  in  DATA_W  result write data.
- finish  in  1  engine completion.
- res_valid  out  1  dump-stream valid.
- res_ready  in  1  dump-stream ready.
- res_addr  out  ADDR_W  address of the current dump word.
- res_data  out  DATA_W  dump word.
- done  out  1  dump complete; sticky.

Behaviour:
- Reset values: state LOAD, load/dump counters 0. img_ready=1; gray_ready, res_valid, done = 0; gray_data=0; res_addr=0.
- Memory arrays are not cleared by reset.
- Unwritten result locations dump as undefined. The engine writes every location, borders included.
- States: LOAD → SERVE → DUMP → DONE.
- LOAD:
  - img_ready=1.
  - Each img_valid&&img_ready cycle writes img_mem[cnt]=img_data, then cnt+1.
  - The handshake at cnt=2^ADDR_W−1 moves to SERVE next cycle; cnt wraps to 0.
  - gray_req and lbp_valid are ignored in LOAD.
- SERVE:
  - gray_ready=1 (level, held), img_ready=0.
  - gray_data = img_mem[gray_addr] in the same cycle while gray_req=1; otherwise 0.
  - lbp_valid=1 writes res_mem[lbp_addr]=lbp_data at the clock edge. A later write to the same address overwrites.
  - finish=1 moves to DUMP next cycle. A lbp_valid in that same cycle is still captured.
- DUMP:
  - gray_ready=0, res_valid=1.
  - res_addr=cnt, res_data=res_mem[cnt], combinational.
  - cnt advances only on res_valid&&res_ready. res_data/res_addr stay stable while stalled.
  - The handshake at the last address goes to DONE.
  - lbp_valid is ignored.
- DONE: res_valid=0, done=1, all inputs ignored until reset.
- Reset asserted mid-operation: immediate return to LOAD state values. The image must be reloaded; old memory contents may persist.
- Widths: counters ADDR_W+1 not needed; terminal detect uses all-ones compare.

Optional Feature:
- Macro: LBP_HOST_PROTOCOL_CHECK_EN.
- When defined:
  - Adds output err (1 bit, reset 0), sticky until reset.
  - err sets on: gray_req=1 outside SERVE; lbp_valid=1 outside SERVE; finish=1 outside SERVE; img_valid=1 outside LOAD.
  - Also adds output wr_cnt (ADDR_W+1 bits, reset 0), counting SERVE-state lbp writes and saturating at max.
- When undefined: ports err and wr_cnt are absent and behaviour is otherwise identical.

Decomposition:
- Shared package lbp_pkg holds:
  - ADDR_W/DATA_W defaults.
  - Image constants IMG_W=128, IMG_H=128.
  - State enum (ST_LOAD, ST_SERVE, ST_DUMP, ST_DONE).
  - Helper for the {row,col} address pack.
- One sub-module is natural: lbp_sp_ram, a 1-write/1-async-read memory, instantiated twice (image, result).
- The top holds the FSM, counters and the optional checker.

Test Plan:
- Load ramp img_data=addr[7:0] for all 16384 pixels → gray_ready rises the cycle after the 16384th handshake. gray_req with gray_addr=0x0081 gives gray_data=0x81 in the same cycle.
- Load stall: img_valid toggled 1/0 every cycle → exactly 16384 writes. img_mem[0x3FFF]=0xFF; gray_ready stays 0 until the last handshake.
- Write capture: lbp_valid with addr 0x0081, data 0xA5, then the same addr with 0x5A → dump word 0x0081 = 0x5A.
- finish and lbp_valid (addr 0x3F7E, data 0x3C) in the same cycle → DUMP next cycle, and word 0x3F7E = 0x3C.
- Dump backpressure: res_ready random 50% → 16384 words in address order 0..16383. No word dropped or duplicated, res_data stable under stall, then done=1 with res_valid=0.
- Reset mid-SERVE → next cycle gray_ready=0, img_ready=1. With LBP_HOST_PROTOCOL_CHECK_EN, gray_req=1 in LOAD gives err=1, cleared only by reset.
